// File: rtl/battle_pkg.sv
// Shared types and helpers for the battlefront calculator: FSM state encoding,
// dead-unit type code, default widths and a width-generic saturating add.
package battle_pkg;

  localparam int unsigned POS_W_DEF = 9;
  localparam int unsigned DMG_W_DEF = 8;
  localparam logic [1:0]  TYPE_DEAD = 2'b00;

  typedef enum logic [5:0] {
    QIdle   = 6'b000001,
    QScan   = 6'b000010,
    QMove   = 6'b000100,
    QSettle = 6'b001000,
    QSum    = 6'b010000,
    QDamage = 6'b100000
  } state_e;

  // Saturates at 2^w-1; operands are zero-extended by the caller.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return (s > m) ? m[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/front_finder.sv
// Serial compare-and-hold over one army: tracks the frontmost live unit's position
// and index (DIR=0 keeps the maximum, DIR=1 the minimum; ties keep the lowest index).
module front_finder #(
  parameter int unsigned POS_W = 9,
  parameter int unsigned IDX_W = 2,
  parameter bit          DIR   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             alive_i,
  input  logic [POS_W-1:0] pos_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [POS_W-1:0] front_pos_o,
  output logic [IDX_W-1:0] front_idx_o,
  output logic             any_alive_o
);

  logic [POS_W-1:0] pos_q;
  logic [IDX_W-1:0] idx_q;
  logic             found_q;
  logic             better;

  always_comb begin
    better = DIR ? (pos_i < pos_q) : (pos_i > pos_q);
  end

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      pos_q   <= '0;
      idx_q   <= '0;
      found_q <= 1'b0;
    end else if (en_i && alive_i && (!found_q || better)) begin
      pos_q   <= pos_i;
      idx_q   <= idx_i;
      found_q <= 1'b1;
    end
  end

  assign front_pos_o = pos_q;
  assign front_idx_o = idx_q;
  assign any_alive_o = found_q;

endmodule

// File: rtl/battle_front.sv
// Battlefront calculator: per game tick, scans both armies, strobes move/damage and
// routes each side's summed attack to the opposing front. Optional macro: BATTLE_SPLASH_EN.
module battle_front
  import battle_pkg::*;
#(
  parameter int unsigned     N_UNITS  = 4,
  parameter int unsigned     POS_W    = POS_W_DEF,
  parameter int unsigned     DMG_W    = DMG_W_DEF,
  parameter logic [POS_W-1:0] BASE_POS = {POS_W{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     gameClk,
  input  logic [N_UNITS*POS_W-1:0] enemyPos,
  input  logic [N_UNITS*2-1:0]     enemyType,
  input  logic [N_UNITS*DMG_W-1:0] enemyDmg,
  input  logic [N_UNITS*POS_W-1:0] playerPos,
  input  logic [N_UNITS*2-1:0]     playerType,
  input  logic [N_UNITS*DMG_W-1:0] playerDmg,
  output logic [POS_W-1:0]         enemyFront,
  output logic [POS_W-1:0]         playerFront,
  output logic                     moveSCEN,
  output logic                     damageSCEN,
  output logic [N_UNITS*DMG_W-1:0] enemyDmgIn,
  output logic [N_UNITS*DMG_W-1:0] playerDmgIn,
  output logic                     busy,
  output logic                     overrun
);

  localparam int unsigned IW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  state_e                   state_q;
  logic [IW-1:0]            idx_q;
  logic                     gclk_q, gclk_qq;
  logic                     tick;
  logic [DMG_W-1:0]         e_sum_q, p_sum_q, e_sum_d, p_sum_d;
  logic [POS_W-1:0]         e_front_q, p_front_q;
  logic                     move_q, dmg_q, busy_q, overrun_q;
  logic [N_UNITS*DMG_W-1:0] e_in_q, p_in_q, e_in_d, p_in_d;

  logic [POS_W-1:0] e_pos [N_UNITS];
  logic [POS_W-1:0] p_pos [N_UNITS];
  logic [DMG_W-1:0] e_dmg [N_UNITS];
  logic [DMG_W-1:0] p_dmg [N_UNITS];
  logic [N_UNITS-1:0] e_live, p_live;

  logic [POS_W-1:0] e_fpos, p_fpos;
  logic [IW-1:0]    e_fidx, p_fidx;
  logic             e_any, p_any;
  logic             last_idx, scan_en, clr;

  always_comb begin
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      e_pos[i]  = enemyPos[i*POS_W +: POS_W];
      p_pos[i]  = playerPos[i*POS_W +: POS_W];
      e_dmg[i]  = enemyDmg[i*DMG_W +: DMG_W];
      p_dmg[i]  = playerDmg[i*DMG_W +: DMG_W];
      e_live[i] = (enemyType[i*2 +: 2] != TYPE_DEAD);
      p_live[i] = (playerType[i*2 +: 2] != TYPE_DEAD);
    end
  end

  assign tick     = gclk_q & ~gclk_qq;
  assign last_idx = (idx_q == IW'(N_UNITS - 1));
  assign scan_en  = (state_q == QScan);
  assign clr      = (state_q == QIdle) && tick;

  front_finder #(.POS_W(POS_W), .IDX_W(IW), .DIR(1'b0)) u_enemy_ff (
    .clk(clk), .reset(reset), .clr_i(clr), .en_i(scan_en), .alive_i(e_live[idx_q]),
    .pos_i(e_pos[idx_q]), .idx_i(idx_q),
    .front_pos_o(e_fpos), .front_idx_o(e_fidx), .any_alive_o(e_any)
  );

  front_finder #(.POS_W(POS_W), .IDX_W(IW), .DIR(1'b1)) u_player_ff (
    .clk(clk), .reset(reset), .clr_i(clr), .en_i(scan_en), .alive_i(p_live[idx_q]),
    .pos_i(p_pos[idx_q]), .idx_i(idx_q),
    .front_pos_o(p_fpos), .front_idx_o(p_fidx), .any_alive_o(p_any)
  );

  always_comb begin
    e_sum_d = e_live[idx_q] ? DMG_W'(sat_add(32'(e_sum_q), 32'(e_dmg[idx_q]), DMG_W)) : e_sum_q;
    p_sum_d = p_live[idx_q] ? DMG_W'(sat_add(32'(p_sum_q), 32'(p_dmg[idx_q]), DMG_W)) : p_sum_q;
  end

  // Player attack lands on enemies, enemy attack on players; final sums include the last index.
  always_comb begin
    e_in_d = '0;
    p_in_d = '0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
`ifdef BATTLE_SPLASH_EN
      if (e_any && e_live[i] && (e_pos[i] == e_fpos)) e_in_d[i*DMG_W +: DMG_W] = p_sum_d;
      if (p_any && p_live[i] && (p_pos[i] == p_fpos)) p_in_d[i*DMG_W +: DMG_W] = e_sum_d;
`else
      if (e_any && (e_fidx == IW'(i))) e_in_d[i*DMG_W +: DMG_W] = p_sum_d;
      if (p_any && (p_fidx == IW'(i))) p_in_d[i*DMG_W +: DMG_W] = e_sum_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= QIdle;
      idx_q     <= '0;
      gclk_q    <= 1'b0;
      gclk_qq   <= 1'b0;
      e_sum_q   <= '0;
      p_sum_q   <= '0;
      e_front_q <= BASE_POS;
      p_front_q <= '0;
      move_q    <= 1'b0;
      dmg_q     <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      e_in_q    <= '0;
      p_in_q    <= '0;
    end else begin
      gclk_q  <= gameClk;
      gclk_qq <= gclk_q;
      move_q  <= 1'b0;
      dmg_q   <= 1'b0;
      e_in_q  <= '0;
      p_in_q  <= '0;
      if (tick && (state_q != QIdle)) overrun_q <= 1'b1;
      case (state_q)
        QIdle: if (tick) begin
          state_q <= QScan;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
        QScan: begin
          idx_q <= idx_q + 1'b1;
          if (last_idx) begin
            idx_q   <= '0;
            state_q <= QMove;
            move_q  <= 1'b1;
          end
        end
        // Finder results settle on the last scan edge, so fronts are captured one cycle later.
        QMove: begin
          e_front_q <= p_any ? p_fpos : BASE_POS;
          p_front_q <= e_any ? e_fpos : '0;
          state_q   <= QSettle;
        end
        QSettle: begin
          e_sum_q <= '0;
          p_sum_q <= '0;
          idx_q   <= '0;
          state_q <= QSum;
        end
        QSum: begin
          e_sum_q <= e_sum_d;
          p_sum_q <= p_sum_d;
          idx_q   <= idx_q + 1'b1;
          if (last_idx) begin
            idx_q   <= '0;
            state_q <= QDamage;
            dmg_q   <= 1'b1;
            e_in_q  <= e_in_d;
            p_in_q  <= p_in_d;
          end
        end
        QDamage: begin
          state_q <= QIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= QIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign enemyFront  = e_front_q;
  assign playerFront = p_front_q;
  assign moveSCEN    = move_q;
  assign damageSCEN  = dmg_q;
  assign enemyDmgIn  = e_in_q;
  assign playerDmgIn = p_in_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_battle_front.sv
// Directed bench for battle_front (N_UNITS=4, POS_W=9, DMG_W=8); expectations are
// hand-computed, with the stacked-front lane depending on BATTLE_SPLASH_EN.
module tb_battle_front;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic gameClk = 1'b0;
  logic [8:0] ep [4];
  logic [8:0] pp [4];
  logic [1:0] et [4];
  logic [1:0] pt [4];
  logic [7:0] ed [4];
  logic [7:0] pd [4];

  logic [35:0] enemyPos, playerPos;
  logic [7:0]  enemyType, playerType;
  logic [31:0] enemyDmg, playerDmg;
  logic [8:0]  enemyFront, playerFront;
  logic        moveSCEN, damageSCEN, busy, overrun;
  logic [31:0] enemyDmgIn, playerDmgIn;

  assign enemyPos   = {ep[3], ep[2], ep[1], ep[0]};
  assign playerPos  = {pp[3], pp[2], pp[1], pp[0]};
  assign enemyType  = {et[3], et[2], et[1], et[0]};
  assign playerType = {pt[3], pt[2], pt[1], pt[0]};
  assign enemyDmg   = {ed[3], ed[2], ed[1], ed[0]};
  assign playerDmg  = {pd[3], pd[2], pd[1], pd[0]};

  battle_front #(.N_UNITS(4), .POS_W(9), .DMG_W(8)) dut (
    .clk(clk), .reset(reset), .gameClk(gameClk),
    .enemyPos(enemyPos), .enemyType(enemyType), .enemyDmg(enemyDmg),
    .playerPos(playerPos), .playerType(playerType), .playerDmg(playerDmg),
    .enemyFront(enemyFront), .playerFront(playerFront),
    .moveSCEN(moveSCEN), .damageSCEN(damageSCEN),
    .enemyDmgIn(enemyDmgIn), .playerDmgIn(playerDmgIn),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mv_at, dm_at, busy_len, mv_cnt, dm_cnt, stray, bad;
  logic [31:0] edi_cap, pdi_cap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle c counts rising edges after gameClk is raised; outputs sampled 1 time unit later.
  task automatic run_round(input int retick, input int abort_at);
    mv_at = -1; dm_at = -1; busy_len = 0; mv_cnt = 0; dm_cnt = 0; stray = 0;
    edi_cap = '0; pdi_cap = '0;
    @(posedge clk); #1 gameClk = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 3) gameClk = 1'b0;
      if (retick > 0 && c == retick) gameClk = 1'b1;
      if (retick > 0 && c == retick + 2) gameClk = 1'b0;
      if (abort_at > 0 && c == abort_at) begin
        reset = 1'b1;
        gameClk = 1'b0;
        return;
      end
      if (busy) busy_len++;
      if (moveSCEN) begin
        mv_cnt++;
        if (mv_at < 0) mv_at = c;
      end
      if (damageSCEN) begin
        dm_cnt++;
        if (dm_at < 0) dm_at = c;
        edi_cap = enemyDmgIn;
        pdi_cap = playerDmgIn;
      end else if (enemyDmgIn != '0 || playerDmgIn != '0) begin
        stray++;
      end
    end
  endtask

  initial begin
    ep[0] = 9'd10;  ep[1] = 9'd40;  ep[2] = 9'd25;  ep[3] = 9'd0;
    pp[0] = 9'd300; pp[1] = 9'd200; pp[2] = 9'd250; pp[3] = 9'h1FF;
    for (int i = 0; i < 4; i++) begin
      et[i] = 2'b01; pt[i] = 2'b01; ed[i] = 8'h20;
    end
    pd[0] = 8'hFF; pd[1] = 8'hFF; pd[2] = 8'h00; pd[3] = 8'h00;

    // Reset state and 50 idle cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enemyFront", 32'(enemyFront), 32'h1FF);
    chk("rst_playerFront", 32'(playerFront), 32'h0);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (moveSCEN || damageSCEN || busy || overrun || enemyDmgIn != '0 || playerDmgIn != '0)
        bad++;
    end
    chk("idle_activity", 32'(bad), 32'd0);
    chk("idle_enemyFront", 32'(enemyFront), 32'h1FF);
    chk("idle_playerFront", 32'(playerFront), 32'h0);

    // Basic round: fronts, strobe timing, routing with saturation
    run_round(0, 0);
    chk("r1_playerFront", 32'(playerFront), 32'd40);
    chk("r1_enemyFront", 32'(enemyFront), 32'd200);
    chk("r1_move_at", 32'(mv_at), 32'd6);
    chk("r1_dmg_at", 32'(dm_at), 32'd12);
    chk("r1_busy_len", 32'(busy_len), 32'd11);
    chk("r1_move_cnt", 32'(mv_cnt), 32'd1);
    chk("r1_dmg_cnt", 32'(dm_cnt), 32'd1);
    chk("r1_playerDmgIn", pdi_cap, 32'h0000_8000);
    chk("r1_enemyDmgIn", edi_cap, 32'h0000_FF00);
    chk("r1_stray_dmg", 32'(stray), 32'd0);
    chk("r1_overrun", 32'(overrun), 32'd0);

    // Stacked enemies at 40, dead far-forward enemy with damage excluded
    ep[2] = 9'd40; ep[3] = 9'd500; et[3] = 2'b00; ed[3] = 8'hFF;
    run_round(0, 0);
    chk("r2_playerFront", 32'(playerFront), 32'd40);
`ifdef BATTLE_SPLASH_EN
    chk("r2_enemyDmgIn", edi_cap, 32'h00FF_FF00);
`else
    chk("r2_enemyDmgIn", edi_cap, 32'h0000_FF00);
`endif
    chk("r2_playerDmgIn", pdi_cap, 32'h0000_6000);

    // No live players, plus a second tick mid-round
    for (int i = 0; i < 4; i++) pt[i] = 2'b00;
    run_round(5, 0);
    chk("r3_enemyFront", 32'(enemyFront), 32'h1FF);
    chk("r3_playerFront", 32'(playerFront), 32'd40);
    chk("r3_enemyDmgIn", edi_cap, 32'h0);
    chk("r3_playerDmgIn", pdi_cap, 32'h0);
    chk("r3_overrun", 32'(overrun), 32'd1);
    chk("r3_move_cnt", 32'(mv_cnt), 32'd1);
    chk("r3_dmg_cnt", 32'(dm_cnt), 32'd1);

    // Reset during the summing phase
    for (int i = 0; i < 4; i++) pt[i] = 2'b01;
    run_round(0, 9);
    chk("r4_dmg_before_abort", 32'(dm_cnt), 32'd0);
    @(posedge clk); #1;
    chk("r4_busy", 32'(busy), 32'd0);
    chk("r4_damageSCEN", 32'(damageSCEN), 32'd0);
    chk("r4_enemyFront", 32'(enemyFront), 32'h1FF);
    chk("r4_playerFront", 32'(playerFront), 32'h0);
    chk("r4_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (damageSCEN || moveSCEN || busy) bad++;
    end
    chk("r4_no_strobe_after", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
